// File: rtl/mbist_march_ctrl_if.sv
// Bus bundle for the March C- BIST controller: start, background mux
// select/return, SRAM control/data and the test status outputs.
interface mbist_march_ctrl_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
);
  logic                  start;
  logic [DATA_WIDTH-1:0] pattern_in;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic [1:0]            bg_sel;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_we;
  logic                  mem_re;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  busy;
  logic                  done;
  logic                  fail;
  logic [ADDR_WIDTH-1:0] fail_addr;
  logic [1:0]            fail_bg;

  // Controller side
  modport master (
    input  start, pattern_in, mem_rdata,
    output bg_sel, mem_addr, mem_we, mem_re, mem_wdata,
           busy, done, fail, fail_addr, fail_bg
  );

  // Environment side (mux, SRAM, test host)
  modport slave (
    output start, pattern_in, mem_rdata,
    input  bg_sel, mem_addr, mem_we, mem_re, mem_wdata,
           busy, done, fail, fail_addr, fail_bg
  );
endinterface

// File: rtl/mbist_march_ctrl.sv
// March C- sequencer for SRAM BIST. Walks four backgrounds (mux sel 0..3),
// running M0..M5 per background at one op per cycle, and compares each read
// one cycle later against the registered expected word.
module mbist_march_ctrl #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  mbist_march_ctrl_if.master bus
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                state_q, state_d;
  logic [2:0]            elem_q, elem_d;
  logic                  op_q, op_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [1:0]            bg_q, bg_d;
  logic                  fail_q, fail_d;
  logic [ADDR_WIDTH-1:0] fail_addr_q, fail_addr_d;
  logic [1:0]            fail_bg_q, fail_bg_d;
  logic                  cmp_vld_q, cmp_vld_d;
  logic [DATA_WIDTH-1:0] cmp_exp_q, cmp_exp_d;
  logic [ADDR_WIDTH-1:0] cmp_addr_q, cmp_addr_d;
  logic [1:0]            cmp_bg_q, cmp_bg_d;

  logic                  running;
  logic                  op_write;
  logic                  op_one;
  logic                  last_op;
  logic                  down;
  logic                  addr_end;
  logic [DATA_WIDTH-1:0] pat_word;

  // Op decode: M0 (w0), M1/M3 (r0,w1), M2/M4 (r1,w0), M5 (r0)
  always_comb begin
    running  = (state_q == RUN);
    op_write = (elem_q == 3'd0) || op_q;
    if ((elem_q == 3'd1) || (elem_q == 3'd3))      op_one = op_q;
    else if ((elem_q == 3'd2) || (elem_q == 3'd4)) op_one = ~op_q;
    else                                           op_one = 1'b0;
    last_op  = ((elem_q == 3'd0) || (elem_q == 3'd5)) ? 1'b1 : op_q;
    down     = (elem_q >= 3'd3);
    addr_end = down ? (addr_q == '0) : (addr_q == '1);
    pat_word = op_one ? ~bus.pattern_in : bus.pattern_in;
  end

  assign bus.bg_sel    = bg_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_we    = running & op_write;
  assign bus.mem_re    = running & ~op_write;
  assign bus.mem_wdata = (running & op_write) ? pat_word : '0;
  assign bus.busy      = (state_q == RUN) || (state_q == DRAIN);
  assign bus.done      = (state_q == DONE);
  assign bus.fail      = fail_q;
  assign bus.fail_addr = fail_addr_q;
  assign bus.fail_bg   = fail_bg_q;

  // Next-state: sequencing counters, read-compare pipeline and fail capture
  always_comb begin
    state_d     = state_q;
    elem_d      = elem_q;
    op_d        = op_q;
    addr_d      = addr_q;
    bg_d        = bg_q;
    fail_d      = fail_q;
    fail_addr_d = fail_addr_q;
    fail_bg_d   = fail_bg_q;
    cmp_vld_d   = 1'b0;
    cmp_exp_d   = cmp_exp_q;
    cmp_addr_d  = cmp_addr_q;
    cmp_bg_d    = cmp_bg_q;

    if (cmp_vld_q && (bus.mem_rdata != cmp_exp_q)) begin
      fail_d = 1'b1;
      if (!fail_q) begin
        fail_addr_d = cmp_addr_q;
        fail_bg_d   = cmp_bg_q;
      end
    end

    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d     = RUN;
          elem_d      = '0;
          op_d        = 1'b0;
          addr_d      = '0;
          bg_d        = '0;
          fail_d      = 1'b0;
          fail_addr_d = '0;
          fail_bg_d   = '0;
        end
      end
      RUN: begin
        if (!op_write) begin
          cmp_vld_d  = 1'b1;
          cmp_exp_d  = pat_word;
          cmp_addr_d = addr_q;
          cmp_bg_d   = bg_q;
        end
        if (!last_op) begin
          op_d = 1'b1;
        end else begin
          op_d = 1'b0;
          if (!addr_end) begin
            addr_d = down ? (addr_q - 1'b1) : (addr_q + 1'b1);
          end else if (elem_q != 3'd5) begin
            // Up elements end at all-ones, down elements at zero; M3..M5
            // start from the top, M1/M2 from the bottom.
            elem_d = elem_q + 3'd1;
            addr_d = (elem_q >= 3'd2) ? '1 : '0;
          end else begin
            elem_d = '0;
            addr_d = '0;
            if (bg_q == 2'd3) state_d = DRAIN;
            else              bg_d    = bg_q + 2'd1;
          end
        end
      end
      DRAIN:   state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // State and pipeline registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      elem_q      <= '0;
      op_q        <= 1'b0;
      addr_q      <= '0;
      bg_q        <= '0;
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_bg_q   <= '0;
      cmp_vld_q   <= 1'b0;
      cmp_exp_q   <= '0;
      cmp_addr_q  <= '0;
      cmp_bg_q    <= '0;
    end else begin
      state_q     <= state_d;
      elem_q      <= elem_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      bg_q        <= bg_d;
      fail_q      <= fail_d;
      fail_addr_q <= fail_addr_d;
      fail_bg_q   <= fail_bg_d;
      cmp_vld_q   <= cmp_vld_d;
      cmp_exp_q   <= cmp_exp_d;
      cmp_addr_q  <= cmp_addr_d;
      cmp_bg_q    <= cmp_bg_d;
    end
  end

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// Bench for mbist_march_ctrl: a 16-word and a 2-word instance, each with an
// SRAM model and background mux. Expected op traces and end results are
// queued at start; negedge monitors pop and compare.
module tb_mbist_march_ctrl;

  typedef struct {
    int         cyc;
    logic [3:0] addr;
    logic       we;
    logic [1:0] bg;
    logic [7:0] wdata;
  } op_t;

  typedef struct {
    int         done_cyc;
    logic       fail;
    logic [3:0] faddr;
    logic [1:0] fbg;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [7:0] pats [4] = '{8'h00, 8'hFF, 8'h55, 8'hAA};

  op_t  q4[$];
  op_t  q1[$];
  res_t r4[$];
  res_t r1[$];

  logic       f5 = 1'b0;
  logic       f9 = 1'b0;
  logic [7:0] mem4 [16];
  logic [7:0] mem1 [2];
  logic [7:0] rdata4 = '0;
  logic [7:0] rdata1 = '0;

  mbist_march_ctrl_if #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) bus4 ();
  mbist_march_ctrl_if #(.ADDR_WIDTH(1), .DATA_WIDTH(8)) bus1 ();

  mbist_march_ctrl #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
  mbist_march_ctrl #(.ADDR_WIDTH(1), .DATA_WIDTH(8)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign bus4.pattern_in = pats[bus4.bg_sel];
  assign bus1.pattern_in = pats[bus1.bg_sel];
  assign bus4.mem_rdata  = rdata4;
  assign bus1.mem_rdata  = rdata1;

  function automatic logic [7:0] fmask(input logic [3:0] a);
    fmask = 8'hFF;
    if (f5 && a == 4'd5) fmask = 8'hFE;
    if (f9 && a == 4'd9) fmask = 8'hFE;
  endfunction

  // SRAM models: write with stuck-at-0 faults, registered read data
  always @(posedge clk) begin
    if (bus4.mem_we) mem4[bus4.mem_addr] <= bus4.mem_wdata & fmask(bus4.mem_addr);
    if (bus4.mem_re) rdata4 <= mem4[bus4.mem_addr];
    if (bus1.mem_we) mem1[bus1.mem_addr] <= bus1.mem_wdata;
    if (bus1.mem_re) rdata1 <= mem1[bus1.mem_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Expected March C- trace; codes 1=w0 2=w1 3=r0 4=r1 0=no op
  task automatic gen(input int which, input int depth, input int t0);
    int  code [6][2] = '{'{1,0}, '{3,2}, '{4,1}, '{3,2}, '{4,1}, '{3,0}};
    int  n = 0;
    int  a;
    op_t e;
    for (int bg = 0; bg < 4; bg++)
      for (int m = 0; m < 6; m++)
        for (int i = 0; i < depth; i++)
          for (int o = 0; o < 2; o++)
            if (code[m][o] != 0) begin
              a       = (m < 3) ? i : depth - 1 - i;
              e.cyc   = t0 + 1 + n;
              e.addr  = a[3:0];
              e.we    = (code[m][o] <= 2);
              e.bg    = bg[1:0];
              e.wdata = (code[m][o] == 2) ? ~pats[bg] : pats[bg];
              n++;
              if (which == 0) q4.push_back(e);
              else            q1.push_back(e);
            end
  endtask

  task automatic issue(input int which, input logic ef, input logic [3:0] ea,
                       input logic [1:0] eb, output int t);
    res_t r;
    int   depth;
    depth = (which == 0) ? 16 : 2;
    @(negedge clk);
    if (which == 0) bus4.start = 1'b1;
    else            bus1.start = 1'b1;
    t = cyc;
    gen(which, depth, t);
    r.done_cyc = t + 40 * depth + 2;
    r.fail     = ef;
    r.faddr    = ea;
    r.fbg      = eb;
    if (which == 0) r4.push_back(r);
    else            r1.push_back(r);
    @(negedge clk);
    bus4.start = 1'b0;
    bus1.start = 1'b0;
    if (which == 0) begin
      chk("busy_after_start", bus4.busy, 1'b1);
      chk("done_cleared", bus4.done, 1'b0);
      chk("fail_cleared", bus4.fail, 1'b0);
    end else begin
      chk("busy1_after_start", bus1.busy, 1'b1);
    end
  endtask

  task automatic wait_done(input int which);
    int n = 0;
    while (((which == 0) ? bus4.done : bus1.done) !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("done_within_budget", (n < 1000), 1'b1);
    @(negedge clk);
  endtask

  // Monitor, 16-word instance
  op_t  m4e;
  res_t m4r;
  logic done4_prev = 1'b0;
  always @(negedge clk) begin
    if (bus4.mem_we || bus4.mem_re) begin
      if (q4.size() == 0) chk("op4_unexpected", 1, 0);
      else begin
        m4e = q4.pop_front();
        chk("op4_cycle", cyc, m4e.cyc);
        chk("op4_addr", bus4.mem_addr, m4e.addr);
        chk("op4_we", bus4.mem_we, m4e.we);
        chk("op4_re", bus4.mem_re, !m4e.we);
        chk("op4_bg", bus4.bg_sel, m4e.bg);
        if (m4e.we) chk("op4_wdata", bus4.mem_wdata, m4e.wdata);
      end
    end
    if (bus4.done && !done4_prev) begin
      if (r4.size() == 0) chk("done4_unexpected", 1, 0);
      else begin
        m4r = r4.pop_front();
        chk("done4_cycle", cyc, m4r.done_cyc);
        chk("busy4_at_done", bus4.busy, 1'b0);
        chk("fail4", bus4.fail, m4r.fail);
        chk("fail_addr4", bus4.fail_addr, m4r.faddr);
        chk("fail_bg4", bus4.fail_bg, m4r.fbg);
        chk("ops4_left", q4.size(), 0);
      end
    end
    done4_prev = bus4.done;
  end

  // Monitor, 2-word instance
  op_t  m1e;
  res_t m1r;
  logic done1_prev = 1'b0;
  always @(negedge clk) begin
    if (bus1.mem_we || bus1.mem_re) begin
      if (q1.size() == 0) chk("op1_unexpected", 1, 0);
      else begin
        m1e = q1.pop_front();
        chk("op1_cycle", cyc, m1e.cyc);
        chk("op1_addr", {3'b000, bus1.mem_addr}, m1e.addr);
        chk("op1_we", bus1.mem_we, m1e.we);
        chk("op1_bg", bus1.bg_sel, m1e.bg);
        if (m1e.we) chk("op1_wdata", bus1.mem_wdata, m1e.wdata);
      end
    end
    if (bus1.done && !done1_prev) begin
      if (r1.size() == 0) chk("done1_unexpected", 1, 0);
      else begin
        m1r = r1.pop_front();
        chk("done1_cycle", cyc, m1r.done_cyc);
        chk("fail1", bus1.fail, m1r.fail);
        chk("ops1_left", q1.size(), 0);
      end
    end
    done1_prev = bus1.done;
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, bus4.busy, 0);
    chk({tag, "_done"}, bus4.done, 0);
    chk({tag, "_fail"}, bus4.fail, 0);
    chk({tag, "_we_re"}, {bus4.mem_we, bus4.mem_re}, 0);
    chk({tag, "_addr"}, bus4.mem_addr, 0);
    chk({tag, "_bg_sel"}, bus4.bg_sel, 0);
    chk({tag, "_wdata"}, bus4.mem_wdata, 0);
    chk({tag, "_fail_addr_bg"}, {bus4.fail_addr, bus4.fail_bg}, 0);
  endtask

  int t;

  initial begin
    bus4.start = 1'b0;
    bus1.start = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // Fault-free run
    issue(0, 1'b0, 4'd0, 2'd0, t);
    wait_done(0);

    // Stuck-at-0 bit0 at addr 5: first miss on M2 r1, bg 0
    f5 = 1'b1;
    issue(0, 1'b1, 4'd5, 2'd0, t);
    wait_done(0);

    // Second fault at addr 9 must not displace the first
    f9 = 1'b1;
    issue(0, 1'b1, 4'd5, 2'd0, t);
    wait_done(0);

    // Restart from DONE clears fail; mid-run start is ignored
    f5 = 1'b0;
    f9 = 1'b0;
    issue(0, 1'b0, 4'd0, 2'd0, t);
    while (cyc < t + 100) @(negedge clk);
    bus4.start = 1'b1;
    @(negedge clk);
    bus4.start = 1'b0;
    wait_done(0);

    // Async reset mid-run, then a complete run
    issue(0, 1'b0, 4'd0, 2'd0, t);
    while (cyc < t + 300) @(negedge clk);
    #2 rst = 1'b1;
    #1 chk_zero("async_rst");
    q4.delete();
    r4.delete();
    @(negedge clk);
    rst = 1'b0;
    issue(0, 1'b0, 4'd0, 2'd0, t);
    wait_done(0);

    // Two-word array
    issue(1, 1'b0, 4'd0, 2'd0, t);
    wait_done(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
